threshold_window_nxn: RTL and testbench

//  Parametrised face-candidate threshold/verify stage for an NxN detection window; sits after the
//  max-score search and before the box-drawing/report logic. Gates a window on its max score, then

---
 rtl/threshold_pkg.sv | 24 ++
 rtl/om_probe_seq.sv | 114 +++++++++++
 rtl/threshold_window_nxn.sv | 100 ++++++++++
 tb/tb_threshold_window_nxn.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/threshold_pkg.sv
// Shared definitions for the window threshold/verify stage: state encoding,
// default thresholds and parameter limits.
package threshold_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ISSUE = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_EVAL  = 3'd3;
  localparam logic [2:0] ST_EMIT  = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE,
    S_ISSUE = ST_ISSUE,
    S_WAIT  = ST_WAIT,
    S_EVAL  = ST_EVAL,
    S_EMIT  = ST_EMIT
  } state_t;

  localparam logic [31:0] DEF_MAX_THR  = 32'h0419_9999;
  localparam logic [31:0] DEF_OM_THR   = 32'h0011_EB85;
  localparam int          MAX_NUM_CAND = 4;
  localparam int          MAX_RD_LAT   = 3;

endpackage

// File: rtl/om_probe_seq.sv
// Centre-probe sequencer: issues OM reads, times the read latency, compares
// against the OM threshold and decides report / retry / fallback / drop.
//
// state  | meaning
// IDLE   | waiting for an accepted window
// ISSUE  | oRd_en high, oAddr_OM = position + CENTER_OFS + k
// WAIT   | counting down the remaining OM latency (skipped when RD_LAT = 1)
// EVAL   | OM data arrives this cycle and is compared
// EMIT   | report pending until the top sees the handshake
module om_probe_seq
  import threshold_pkg::*;
#(
  parameter int ADDR_W       = 13,
  parameter int DATA_W       = 32,
  parameter int CENTER_OFS   = 162,
  parameter int NUM_CAND     = 2,
  parameter bit FALLBACK_EN  = 1'b1,
  parameter int FALLBACK_OFS = 81,
  parameter int RD_LAT       = 1
) (
  input  logic              iClk,
  input  logic              iReset_n,
  input  logic              iClear,
  input  logic              iStart,
  input  logic [ADDR_W-1:0] iPosition,
  input  logic [DATA_W-1:0] iData_from_OM,
  input  logic [DATA_W-1:0] iOm_thr,
  input  logic              iAck,
  output logic [ADDR_W-1:0] oAddr_OM,
  output logic              oRd_en,
  output logic              oReport,
  output logic              oDrop,
  output logic [ADDR_W-1:0] oRep_pos
);

  localparam logic [1:0] K_LAST   = 2'(NUM_CAND - 1);
  localparam logic [1:0] LAT_LOAD = (RD_LAT > 1) ? 2'(RD_LAT - 2) : 2'd0;

  state_t            r_state, w_next;
  logic [1:0]        r_k, w_k_next;
  logic [1:0]        r_lat, w_lat_next;
  logic [ADDR_W-1:0] r_pos, r_addr, w_base, w_addr_next;
  logic              r_rd_en;

  always_comb begin
    w_next     = r_state;
    w_k_next   = r_k;
    w_lat_next = r_lat;
    w_base     = (r_state == S_IDLE) ? iPosition : r_pos;
    oReport    = 1'b0;
    oDrop      = 1'b0;
    oRep_pos   = r_pos + ADDR_W'(r_k);
    unique case (r_state)
      S_IDLE: begin
        if (iStart) begin
          w_next   = S_ISSUE;
          w_k_next = 2'd0;
        end
      end
      S_ISSUE: begin
        w_lat_next = LAT_LOAD;
        w_next     = (RD_LAT == 1) ? S_EVAL : S_WAIT;
      end
      S_WAIT: begin
        if (r_lat == 2'd0) w_next = S_EVAL;
        else               w_lat_next = r_lat - 2'd1;
      end
      S_EVAL: begin
        if (iData_from_OM > iOm_thr) begin
          oReport = 1'b1;
          w_next  = S_EMIT;
        end else if (r_k != K_LAST) begin
          w_k_next = r_k + 2'd1;
          w_next   = S_ISSUE;
        end else if (FALLBACK_EN) begin
          oReport  = 1'b1;
          oRep_pos = r_pos + ADDR_W'(FALLBACK_OFS);
          w_next   = S_EMIT;
        end else begin
          oDrop  = 1'b1;
          w_next = S_IDLE;
        end
      end
      S_EMIT: begin
        if (iAck) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    // Address for the probe about to be issued; wraps modulo 2^ADDR_W
    w_addr_next = w_base + ADDR_W'(CENTER_OFS) + ADDR_W'(w_k_next);
  end

  always_ff @(posedge iClk) begin
    if (!iReset_n || iClear) begin
      r_state <= S_IDLE;
      r_k     <= 2'd0;
      r_lat   <= 2'd0;
      r_pos   <= '0;
      r_addr  <= '0;
      r_rd_en <= 1'b0;
    end else begin
      r_state <= w_next;
      r_k     <= w_k_next;
      r_lat   <= w_lat_next;
      r_rd_en <= (w_next == S_ISSUE);
      if (w_next == S_ISSUE) r_addr <= w_addr_next;
      if (r_state == S_IDLE && iStart) r_pos <= iPosition;
    end
  end

  assign oAddr_OM = r_addr;
  assign oRd_en   = r_rd_en;

endmodule

// File: rtl/threshold_window_nxn.sv
// Face-candidate threshold/verify stage: gates a window on its max score, probes
// the centre OM words and reports the corrected position over valid/ready.
module threshold_window_nxn
  import threshold_pkg::*;
#(
  parameter int WIN          = 19,
  parameter int ADDR_W       = 13,
  parameter int DATA_W       = 32,
  parameter int CENTER_OFS   = 162,
  parameter int NUM_CAND     = 2,
  parameter bit FALLBACK_EN  = 1'b1,
  parameter int FALLBACK_OFS = (WIN / 2) * (WIN / 2),
  parameter int RD_LAT       = 1,
  parameter int CNT_W        = 16
) (
  input  logic              iClk,
  input  logic              iReset_n,
  input  logic              iFinish,
  input  logic              iInput_ready,
  input  logic [ADDR_W-1:0] iPosition,
  input  logic [DATA_W-1:0] iMax_val,
  input  logic [DATA_W-1:0] iMax_thr,
  input  logic [DATA_W-1:0] iOm_thr,
  output logic              oBusy,
  output logic [ADDR_W-1:0] oAddr_OM,
  output logic              oRd_en,
  input  logic [DATA_W-1:0] iData_from_OM,
  output logic [ADDR_W-1:0] oPosition,
  output logic              oOutput_valid,
  input  logic              iOutput_ready,
  output logic              oEnd,
  output logic [CNT_W-1:0]  oDet_count
);

  logic              r_busy, r_valid, r_end;
  logic [ADDR_W-1:0] r_position;
  logic [CNT_W-1:0]  r_count;
  logic              w_above, w_accept, w_ack, w_report, w_drop;
  logic [ADDR_W-1:0] w_rep_pos;

  assign w_above  = iMax_val > iMax_thr;
  assign w_accept = iInput_ready && !r_busy && w_above;
  assign w_ack    = r_valid && iOutput_ready;

  om_probe_seq #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .CENTER_OFS  (CENTER_OFS),
    .NUM_CAND    (NUM_CAND),
    .FALLBACK_EN (FALLBACK_EN),
    .FALLBACK_OFS(FALLBACK_OFS),
    .RD_LAT      (RD_LAT)
  ) u_probe (
    .iClk         (iClk),
    .iReset_n     (iReset_n),
    .iClear       (iFinish),
    .iStart       (w_accept),
    .iPosition    (iPosition),
    .iData_from_OM(iData_from_OM),
    .iOm_thr      (iOm_thr),
    .iAck         (w_ack),
    .oAddr_OM     (oAddr_OM),
    .oRd_en       (oRd_en),
    .oReport      (w_report),
    .oDrop        (w_drop),
    .oRep_pos     (w_rep_pos)
  );

  always_ff @(posedge iClk) begin
    if (!iReset_n || iFinish) begin
      r_busy     <= 1'b0;
      r_valid    <= 1'b0;
      r_end      <= 1'b0;
      r_position <= '0;
      r_count    <= '0;
    end else begin
      if (w_accept)             r_busy <= 1'b1;
      else if (w_drop || w_ack) r_busy <= 1'b0;

      if (w_report) begin
        r_valid    <= 1'b1;
        r_position <= w_rep_pos;
      end else if (w_ack) begin
        r_valid <= 1'b0;
      end

      // oEnd tracks only windows actually sampled while idle
      if (iInput_ready && !r_busy) r_end <= !w_above;

      if (w_ack && r_count != {CNT_W{1'b1}}) r_count <= r_count + CNT_W'(1);
    end
  end

  assign oBusy         = r_busy;
  assign oOutput_valid = r_valid;
  assign oPosition     = r_position;
  assign oEnd          = r_end;
  assign oDet_count    = r_count;

endmodule

// File: tb/tb_threshold_window_nxn.sv
// Directed bench for threshold_window_nxn: instance 0 default, 1 with no fallback
// and a 2-bit counter, 2 with RD_LAT=3; each instance has its own OM read model.
module tb_threshold_window_nxn;
  localparam int AW = 13;
  localparam int DW = 32;
  localparam logic [DW-1:0] FILL  = 32'hFFFF_FFFF;
  localparam logic [DW-1:0] ABOVE = 32'h0419_999A;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, finish, out_rdy;
  logic [AW-1:0] pos;
  logic [DW-1:0] max_val, max_thr, om_thr;
  logic          in_rdy [3];
  logic          busy [3], rd [3], valid [3], endf [3];
  logic [AW-1:0] addr [3], opos [3];
  logic [DW-1:0] data [3];
  logic [15:0]   cnt_a, cnt_c;
  logic [1:0]    cnt_b;

  logic [DW-1:0] om [0:8191];
  logic [DW-1:0] pipe [3][3];

  threshold_window_nxn u_a (
    .iClk(clk), .iReset_n(rst_n), .iFinish(finish), .iInput_ready(in_rdy[0]),
    .iPosition(pos), .iMax_val(max_val), .iMax_thr(max_thr), .iOm_thr(om_thr),
    .oBusy(busy[0]), .oAddr_OM(addr[0]), .oRd_en(rd[0]), .iData_from_OM(data[0]),
    .oPosition(opos[0]), .oOutput_valid(valid[0]), .iOutput_ready(out_rdy),
    .oEnd(endf[0]), .oDet_count(cnt_a));

  threshold_window_nxn #(.FALLBACK_EN(1'b0), .CNT_W(2)) u_b (
    .iClk(clk), .iReset_n(rst_n), .iFinish(finish), .iInput_ready(in_rdy[1]),
    .iPosition(pos), .iMax_val(max_val), .iMax_thr(max_thr), .iOm_thr(om_thr),
    .oBusy(busy[1]), .oAddr_OM(addr[1]), .oRd_en(rd[1]), .iData_from_OM(data[1]),
    .oPosition(opos[1]), .oOutput_valid(valid[1]), .iOutput_ready(out_rdy),
    .oEnd(endf[1]), .oDet_count(cnt_b));

  threshold_window_nxn #(.RD_LAT(3)) u_c (
    .iClk(clk), .iReset_n(rst_n), .iFinish(finish), .iInput_ready(in_rdy[2]),
    .iPosition(pos), .iMax_val(max_val), .iMax_thr(max_thr), .iOm_thr(om_thr),
    .oBusy(busy[2]), .oAddr_OM(addr[2]), .oRd_en(rd[2]), .iData_from_OM(data[2]),
    .oPosition(opos[2]), .oOutput_valid(valid[2]), .iOutput_ready(out_rdy),
    .oEnd(endf[2]), .oDet_count(cnt_c));

  // OM model: data shows up RD_LAT cycles after the strobe, passing filler otherwise
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      pipe[i][0] <= rd[i] ? om[addr[i]] : FILL;
      pipe[i][1] <= pipe[i][0];
      pipe[i][2] <= pipe[i][1];
    end
  end
  assign data[0] = pipe[0][0];
  assign data[1] = pipe[1][0];
  assign data[2] = pipe[2][2];

  int n_pass = 0;
  int n_chk  = 0;
  int lat, nreads;
  logic [AW-1:0] first_addr, last_addr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Pulse one window into instance s, then follow it until report or drop (bounded)
  task automatic run_window(input int s, input logic [AW-1:0] p, input logic [DW-1:0] mx);
    pos = p; max_val = mx; in_rdy[s] = 1'b1;
    step();
    in_rdy[s] = 1'b0;
    lat = 1; nreads = 0; first_addr = '0; last_addr = '0;
    for (int i = 0; i < 30; i++) begin
      if (rd[s]) begin
        if (nreads == 0) first_addr = addr[s];
        last_addr = addr[s];
        nreads++;
      end
      if (valid[s] || !busy[s]) break;
      step();
      lat++;
    end
  endtask

  task automatic ack();
    out_rdy = 1'b1;
    step();
    out_rdy = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) om[i] = '0;
    rst_n = 1'b0; finish = 1'b0; out_rdy = 1'b0;
    pos = '0; max_val = '0; max_thr = 32'h0419_9999; om_thr = 32'h0011_EB85;
    for (int i = 0; i < 3; i++) in_rdy[i] = 1'b0;
    repeat (3) step();
    chk("rst_busy",  32'(busy[0]),  0);
    chk("rst_valid", 32'(valid[0]), 0);
    chk("rst_rd",    32'(rd[0]),    0);
    chk("rst_addr",  32'(addr[0]),  0);
    chk("rst_pos",   32'(opos[0]),  0);
    chk("rst_end",   32'(endf[0]),  0);
    chk("rst_cnt",   32'(cnt_a),    0);
    rst_n = 1'b1;
    step();

    // score equal to threshold: rejected, oEnd set and held
    pos = 13'd55; max_val = 32'h0419_9999; in_rdy[0] = 1'b1;
    step();
    in_rdy[0] = 1'b0;
    chk("eq_end",  32'(endf[0]), 1);
    chk("eq_busy", 32'(busy[0]), 0);
    chk("eq_rd",   32'(rd[0]),   0);
    step(); step();
    chk("eq_end_hold", 32'(endf[0]), 1);
    chk("eq_rd_hold",  32'(rd[0]),   0);

    // first probe passes
    om[262] = 32'h0011_EB86;
    run_window(0, 13'd100, ABOVE);
    chk("p1_lat",   32'(lat),        3);
    chk("p1_addr",  32'(first_addr), 262);
    chk("p1_reads", 32'(nreads),     1);
    chk("p1_valid", 32'(valid[0]),   1);
    chk("p1_pos",   32'(opos[0]),    100);
    chk("p1_end",   32'(endf[0]),    0);
    ack();
    chk("p1_valid_drop", 32'(valid[0]), 0);
    chk("p1_busy_drop",  32'(busy[0]),  0);
    chk("p1_cnt",        32'(cnt_a),    1);

    // second probe passes
    om[262] = '0; om[263] = 32'h0020_0000;
    run_window(0, 13'd100, ABOVE);
    chk("p2_lat",   32'(lat),       5);
    chk("p2_reads", 32'(nreads),    2);
    chk("p2_addr",  32'(last_addr), 263);
    chk("p2_pos",   32'(opos[0]),   101);
    ack();
    chk("p2_cnt", 32'(cnt_a), 2);

    // both probes fail: fallback position
    om[263] = '0;
    run_window(0, 13'd100, ABOVE);
    chk("fb_lat",   32'(lat),      5);
    chk("fb_valid", 32'(valid[0]), 1);
    chk("fb_pos",   32'(opos[0]),  181);
    ack();
    chk("fb_cnt", 32'(cnt_a), 3);

    // address wrap
    om[70] = 32'h0011_EB86;
    run_window(0, 13'd8100, ABOVE);
    chk("wr_addr", 32'(first_addr), 70);
    chk("wr_lat",  32'(lat),        3);
    chk("wr_pos",  32'(opos[0]),    8100);
    ack();
    chk("wr_cnt", 32'(cnt_a), 4);
    om[70] = '0;

    // backpressure with ignored input pulses
    om[262] = 32'h0011_EB86;
    run_window(0, 13'd100, ABOVE);
    chk("bp_valid0", 32'(valid[0]), 1);
    for (int i = 0; i < 5; i++) begin
      pos = 13'(200 + i); in_rdy[0] = 1'b1;
      step();
      chk("bp_valid", 32'(valid[0]), 1);
      chk("bp_pos",   32'(opos[0]),  100);
      chk("bp_rd",    32'(rd[0]),    0);
    end
    in_rdy[0] = 1'b0;
    ack();
    chk("bp_cnt",       32'(cnt_a),    5);
    chk("bp_valid_end", 32'(valid[0]), 0);
    step();
    chk("bp_busy_idle", 32'(busy[0]), 0);
    chk("bp_rd_idle",   32'(rd[0]),   0);

    // no-fallback instance: saturating 2-bit counter, then a dropped window
    for (int i = 0; i < 4; i++) begin
      run_window(1, 13'd100, ABOVE);
      chk("nf_valid", 32'(valid[1]), 1);
      ack();
      chk("nf_cnt", 32'(cnt_b), (i < 3) ? i + 1 : 3);
    end
    om[262] = '0;
    run_window(1, 13'd100, ABOVE);
    chk("nf_drop_lat",   32'(lat),      5);
    chk("nf_drop_reads", 32'(nreads),   2);
    chk("nf_drop_valid", 32'(valid[1]), 0);
    chk("nf_drop_busy",  32'(busy[1]),  0);
    chk("nf_drop_cnt",   32'(cnt_b),    3);

    // RD_LAT=3 instance
    om[262] = 32'h0011_EB86;
    run_window(2, 13'd100, ABOVE);
    chk("l3_lat",   32'(lat),     5);
    chk("l3_reads", 32'(nreads),  1);
    chk("l3_pos",   32'(opos[2]), 100);
    ack();
    chk("l3_cnt", 32'(cnt_c), 1);

    // iFinish while waiting on OM data
    pos = 13'd100; max_val = ABOVE; in_rdy[2] = 1'b1;
    step();
    in_rdy[2] = 1'b0;
    chk("fin_rd_issue", 32'(rd[2]), 1);
    step();
    finish = 1'b1;
    step();
    finish = 1'b0;
    chk("fin_busy",  32'(busy[2]),  0);
    chk("fin_valid", 32'(valid[2]), 0);
    chk("fin_rd",    32'(rd[2]),    0);
    chk("fin_addr",  32'(addr[2]),  0);
    chk("fin_pos",   32'(opos[2]),  0);
    chk("fin_cnt",   32'(cnt_c),    0);
    chk("fin_cnt_a", 32'(cnt_a),    0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("fin_stale_valid", 32'(valid[2]), 0);
      chk("fin_stale_busy",  32'(busy[2]),  0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
